rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of write data.
REQ-002 Parameter MAX_BURST, default 4, maximum beats per ownership; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 req0_valid  input  1  requester 0 has a write beat.
REQ-006 req0_addr  input  3  requester 0 target register (0..7).
REQ-007 req0_data  input  DATA_WIDTH  requester 0 write data.
REQ-008 req0_last  input  1  final beat of requester 0 burst.
REQ-009 req0_ready  output  1  arbiter accepts requester 0 beat.
REQ-010 req1_valid, req1_addr, req1_data, req1_last, req1_ready: same directions, widths and meanings as REQ-005..009, for requester 1.
REQ-011 we  output  1  register-file write enable.
REQ-012 wAddr  output  3  register-file write address.
REQ-013 wData  output  DATA_WIDTH  register-file write data.
REQ-014 owner  output  2  one-hot current owner (bit0 = req0, bit1 = req1); 00 when idle.

Function
REQ-015 Transfer on requester N: reqN_valid and reqN_ready both 1 at a rising edge.
REQ-016 States IDLE, OWN0, OWN1; reqN_ready SHALL be 1 exactly when state is OWNN, with no combinational path from any input.
REQ-017 IDLE: only req0_valid -> OWN0; only req1_valid -> OWN1; both -> OWN of round-robin pointer rr; neither -> stay IDLE.
REQ-018 OWNN: owner may drop valid without releasing; state holds OWNN while no release condition is met.
REQ-019 Release condition in OWNN: transfer with reqN_last = 1, or transfer that completes the MAX_BURST-th beat of the current ownership.
REQ-020 On release: if other requester's valid = 1 that cycle -> OWN(other) next cycle with no IDLE gap; else -> IDLE.
REQ-021 rr SHALL update to the non-releasing requester on every release; rr is unchanged by grants from IDLE with a single requester.
REQ-022 Beat counter: 4 bits, cleared on entering any OWN state, incremented per owner transfer; never exceeds MAX_BURST.
REQ-023 Latency: we = 1 in the cycle after a transfer, with wAddr/wData equal to the transferred beat's addr/data; one write per transfer, no drops, no duplicates.
REQ-024 No transfer in a cycle -> we = 0 next cycle; wAddr/wData hold last value.
REQ-025 Identical addresses from both requesters are not special; order of writes follows grant order.
REQ-026 owner SHALL reflect state (OWN0 -> 01, OWN1 -> 10, IDLE -> 00).

Reset
REQ-027 reset_n low SHALL asynchronously force: state IDLE, rr = 0, beat counter 0, we 0, wAddr 0, wData 0, owner 00, both ready 0.
REQ-028 Reset mid-burst SHALL discard the burst; no we pulse after reset deassertion until a new transfer.
REQ-029 First grant after reset with both valid SHALL go to requester 0.

Structure
REQ-030 Shared package rf_pkg SHALL hold RF_ADDR_WIDTH = 3, RF_NUM_REGS = 8 and the arbiter state enumeration.
REQ-031 One sub-module, rr_pick2 (2-way round-robin pick from valids and rr), is natural; the rest is flat.

Verification
REQ-032 Reset then req0 single beat addr 5 data 0xA5A5A5A5 last=1 -> OWN0 next cycle, transfer, we=1 wAddr=5 wData=0xA5A5A5A5 one cycle later, then IDLE.
REQ-033 Both valid continuously, single-beat last=1 bursts -> grants alternate 0,1,0,1 with no IDLE cycles; one write per cycle after first grant.
REQ-034 req0 holds valid with last=0 for 10 beats, MAX_BURST=4, req1 valid -> req0 gets 4 beats, req1 granted, req0 regains after req1 releases.
REQ-035 req1 in OWN1 drops valid two cycles mid-burst -> we=0 those cycles, req0 not granted, burst resumes to last.
REQ-036 reset_n pulsed low mid-burst after beat 2 -> all outputs 0 immediately, no further we; next both-valid grant to req0.
REQ-037 Both requesters target addr 3 data 0x11 / 0x22 same cycle from IDLE rr=0 -> writes 0x11 then 0x22 to addr 3 on consecutive transfer cycles.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file definitions and the write-arbiter state encoding.
package rf_pkg;

    localparam int RF_ADDR_WIDTH = 3;
    localparam int RF_NUM_REGS   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    // One-hot owner code presented to the outside world for a given state.
    function automatic logic [1:0] owner_of(input arb_state_t s);
        case (s)
            ST_OWN0: owner_of = 2'b01;
            ST_OWN1: owner_of = 2'b10;
            default: owner_of = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to rr.
module rr_pick2 (
    input  logic       valid0,
    input  logic       valid1,
    input  logic       rr,
    output logic [1:0] grant
);

    assign grant[0] = valid0 & (~valid1 | ~rr);
    assign grant[1] = valid1 & (~valid0 |  rr);

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates two bursting write requesters onto a single register-file write port.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,

    input  logic                     req0_valid,
    input  logic [RF_ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0]    req0_data,
    input  logic                     req0_last,
    output logic                     req0_ready,

    input  logic                     req1_valid,
    input  logic [RF_ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0]    req1_data,
    input  logic                     req1_last,
    output logic                     req1_ready,

    output logic                     we,
    output logic [RF_ADDR_WIDTH-1:0] wAddr,
    output logic [DATA_WIDTH-1:0]    wData,
    output logic [1:0]               owner
);

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    arb_state_t state;
    logic       rr;
    logic [3:0] beat_cnt;
    logic [3:0] beat_inc;
    logic [1:0] grant;
    logic       xfer0;
    logic       xfer1;
    logic       at_limit;
    logic       release0;
    logic       release1;

    // Ready is taken straight from the owner register, so it never depends on inputs.
    assign req0_ready = owner[0];
    assign req1_ready = owner[1];

    assign xfer0    = req0_valid & req0_ready;
    assign xfer1    = req1_valid & req1_ready;
    assign beat_inc = beat_cnt + 4'd1;
    assign at_limit = (beat_inc == BURST_LIM);
    assign release0 = xfer0 & (req0_last | at_limit);
    assign release1 = xfer1 & (req1_last | at_limit);

    rr_pick2 u_pick (
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .rr     (rr),
        .grant  (grant)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            owner    <= owner_of(ST_IDLE);
            rr       <= 1'b0;
            beat_cnt <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant[0]) begin
                        state    <= ST_OWN0;
                        owner    <= owner_of(ST_OWN0);
                        beat_cnt <= 4'd0;
                    end else if (grant[1]) begin
                        state    <= ST_OWN1;
                        owner    <= owner_of(ST_OWN1);
                        beat_cnt <= 4'd0;
                    end
                end
                ST_OWN0: begin
                    if (release0) begin
                        rr       <= 1'b1;
                        beat_cnt <= 4'd0;
                        if (req1_valid) begin
                            state <= ST_OWN1;
                            owner <= owner_of(ST_OWN1);
                        end else begin
                            state <= ST_IDLE;
                            owner <= owner_of(ST_IDLE);
                        end
                    end else if (xfer0) begin
                        beat_cnt <= beat_inc;
                    end
                end
                ST_OWN1: begin
                    if (release1) begin
                        rr       <= 1'b0;
                        beat_cnt <= 4'd0;
                        if (req0_valid) begin
                            state <= ST_OWN0;
                            owner <= owner_of(ST_OWN0);
                        end else begin
                            state <= ST_IDLE;
                            owner <= owner_of(ST_IDLE);
                        end
                    end else if (xfer1) begin
                        beat_cnt <= beat_inc;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    owner    <= owner_of(ST_IDLE);
                    beat_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Each accepted beat becomes exactly one write on the following cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we    <= 1'b0;
            wAddr <= '0;
            wData <= '0;
        end else if (xfer0) begin
            we    <= 1'b1;
            wAddr <= req0_addr;
            wData <= req0_data;
        end else if (xfer1) begin
            we    <= 1'b1;
            wAddr <= req1_addr;
            wData <= req1_data;
        end else begin
            we    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a write scoreboard drained by a monitor.
module tb_rf_write_arbiter;

    logic        clk;
    logic        reset_n;
    logic        req0_valid;
    logic [2:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_last;
    logic        req0_ready;
    logic        req1_valid;
    logic [2:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_last;
    logic        req1_ready;
    logic        we;
    logic [2:0]  wAddr;
    logic [31:0] wData;
    logic [1:0]  owner;

    typedef struct packed {
        logic [2:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    rf_write_arbiter #(.DATA_WIDTH(32), .MAX_BURST(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .we         (we),
        .wAddr      (wAddr),
        .wData      (wData),
        .owner      (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectWrite(input logic [2:0] a, input logic [31:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    // One cycle: check the owner/ready seen this cycle, then drive the inputs sampled at the next edge.
    task automatic applyStimulus(input logic [1:0] exp_owner,
                                 input logic v0, input logic [2:0] a0, input logic [31:0] d0, input logic l0,
                                 input logic v1, input logic [2:0] a1, input logic [31:0] d1, input logic l1);
        @(negedge clk);
        checkOutput("owner", 64'(owner), 64'(exp_owner));
        checkOutput("ready", 64'({req1_ready, req0_ready}), 64'(exp_owner));
        req0_valid = v0; req0_addr = a0; req0_data = d0; req0_last = l0;
        req1_valid = v1; req1_addr = a1; req1_data = d1; req1_last = l1;
    endtask

    task automatic idleInputs();
        req0_valid = 1'b0; req0_addr = 3'd0; req0_data = 32'd0; req0_last = 1'b0;
        req1_valid = 1'b0; req1_addr = 3'd0; req1_data = 32'd0; req1_last = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_we"},    64'(we),    64'd0);
        checkOutput({tag, "_wAddr"}, 64'(wAddr), 64'd0);
        checkOutput({tag, "_wData"}, 64'(wData), 64'd0);
        checkOutput({tag, "_owner"}, 64'(owner), 64'd0);
        checkOutput({tag, "_ready"}, 64'({req1_ready, req0_ready}), 64'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        idleInputs();
        #2 reset_n = 1'b0;
        #1 checkResetOutputs("reset");
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: every write the DUT presents must be the next one the scoreboard expects.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write: got addr %0d data 0x%0h, expected no write", wAddr, wData);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("wAddr", 64'(wAddr), 64'(e.addr));
                    checkOutput("wData", 64'(wData), 64'(e.data));
                end
            end
        end
    end

    initial begin
        idleInputs();
        reset_n = 1'b0;
        #1 checkResetOutputs("por");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Single beat from req0.
        expectWrite(3'd5, 32'hA5A5A5A5);
        applyStimulus(2'b00, 1, 3'd5, 32'hA5A5A5A5, 1, 0, 3'd0, 32'd0, 0);
        applyStimulus(2'b01, 1, 3'd5, 32'hA5A5A5A5, 1, 0, 3'd0, 32'd0, 0);
        applyStimulus(2'b00, 0, 3'd0, 32'd0, 0, 0, 3'd0, 32'd0, 0);
        applyStimulus(2'b00, 0, 3'd0, 32'd0, 0, 0, 3'd0, 32'd0, 0);

        // Both valid with single-beat bursts: strict alternation, no idle gaps.
        doReset();
        expectWrite(3'd1, 32'h10); expectWrite(3'd2, 32'h20);
        expectWrite(3'd1, 32'h10); expectWrite(3'd2, 32'h20);
        expectWrite(3'd1, 32'h10);
        applyStimulus(2'b00, 1, 3'd1, 32'h10, 1, 1, 3'd2, 32'h20, 1);
        applyStimulus(2'b01, 1, 3'd1, 32'h10, 1, 1, 3'd2, 32'h20, 1);
        applyStimulus(2'b10, 1, 3'd1, 32'h10, 1, 1, 3'd2, 32'h20, 1);
        applyStimulus(2'b01, 1, 3'd1, 32'h10, 1, 1, 3'd2, 32'h20, 1);
        applyStimulus(2'b10, 1, 3'd1, 32'h10, 1, 1, 3'd2, 32'h20, 1);
        applyStimulus(2'b01, 1, 3'd1, 32'h10, 1, 0, 3'd0, 32'd0, 0);
        applyStimulus(2'b00, 0, 3'd0, 32'd0, 0, 0, 3'd0, 32'd0, 0);

        // Long req0 burst is cut at four beats while req1 waits.
        doReset();
        expectWrite(3'd4, 32'h40); expectWrite(3'd4, 32'h41);
        expectWrite(3'd4, 32'h42); expectWrite(3'd4, 32'h43);
        expectWrite(3'd7, 32'h77);
        expectWrite(3'd4, 32'h44); expectWrite(3'd4, 32'h45);
        expectWrite(3'd4, 32'h46); expectWrite(3'd4, 32'h47);
        expectWrite(3'd4, 32'h48); expectWrite(3'd4, 32'h49);
        applyStimulus(2'b00, 1, 3'd4, 32'h40, 0, 1, 3'd7, 32'h77, 1);
        applyStimulus(2'b01, 1, 3'd4, 32'h40, 0, 1, 3'd7, 32'h77, 1);
        applyStimulus(2'b01, 1, 3'd4, 32'h41, 0, 1, 3'd7, 32'h77, 1);
        applyStimulus(2'b01, 1, 3'd4, 32'h42, 0, 1, 3'd7, 32'h77, 1);
        applyStimulus(2'b01, 1, 3'd4, 32'h43, 0, 1, 3'd7, 32'h77, 1);
        applyStimulus(2'b10, 1, 3'd4, 32'h44, 0, 1, 3'd7, 32'h77, 1);
        applyStimulus(2'b01, 1, 3'd4, 32'h44, 0, 0, 3'd0, 32'd0, 0);
        applyStimulus(2'b01, 1, 3'd4, 32'h45, 0, 0, 3'd0, 32'd0, 0);
        applyStimulus(2'b01, 1, 3'd4, 32'h46, 0, 0, 3'd0, 32'd0, 0);
        applyStimulus(2'b01, 1, 3'd4, 32'h47, 0, 0, 3'd0, 32'd0, 0);
        applyStimulus(2'b00, 1, 3'd4, 32'h48, 0, 0, 3'd0, 32'd0, 0);
        applyStimulus(2'b01, 1, 3'd4, 32'h48, 0, 0, 3'd0, 32'd0, 0);
        applyStimulus(2'b01, 1, 3'd4, 32'h49, 1, 0, 3'd0, 32'd0, 0);
        applyStimulus(2'b00, 0, 3'd0, 32'd0, 0, 0, 3'd0, 32'd0, 0);

        // req1 pauses mid-burst; req0 must wait until req1 finishes.
        expectWrite(3'd6, 32'h60); expectWrite(3'd6, 32'h61);
        expectWrite(3'd6, 32'h62); expectWrite(3'd0, 32'h05);
        applyStimulus(2'b00, 0, 3'd0, 32'd0, 0, 1, 3'd6, 32'h60, 0);
        applyStimulus(2'b10, 0, 3'd0, 32'd0, 0, 1, 3'd6, 32'h60, 0);
        applyStimulus(2'b10, 1, 3'd0, 32'h05, 1, 0, 3'd0, 32'd0, 0);
        applyStimulus(2'b10, 1, 3'd0, 32'h05, 1, 0, 3'd0, 32'd0, 0);
        applyStimulus(2'b10, 1, 3'd0, 32'h05, 1, 1, 3'd6, 32'h61, 0);
        applyStimulus(2'b10, 1, 3'd0, 32'h05, 1, 1, 3'd6, 32'h62, 1);
        applyStimulus(2'b01, 1, 3'd0, 32'h05, 1, 0, 3'd0, 32'd0, 0);
        applyStimulus(2'b00, 0, 3'd0, 32'd0, 0, 0, 3'd0, 32'd0, 0);

        // Reset lands after the second beat of a req0 burst.
        expectWrite(3'd2, 32'h200); expectWrite(3'd2, 32'h201);
        applyStimulus(2'b00, 1, 3'd2, 32'h200, 0, 0, 3'd0, 32'd0, 0);
        applyStimulus(2'b01, 1, 3'd2, 32'h200, 0, 0, 3'd0, 32'd0, 0);
        applyStimulus(2'b01, 1, 3'd2, 32'h201, 0, 0, 3'd0, 32'd0, 0);
        applyStimulus(2'b01, 1, 3'd2, 32'h202, 0, 0, 3'd0, 32'd0, 0);
        #2 reset_n = 1'b0;
        #1 checkResetOutputs("midburst");
        idleInputs();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(2'b00, 0, 3'd0, 32'd0, 0, 0, 3'd0, 32'd0, 0);

        // Same address from both requesters after reset: req0 first, then req1.
        expectWrite(3'd3, 32'h11); expectWrite(3'd3, 32'h22);
        applyStimulus(2'b00, 1, 3'd3, 32'h11, 1, 1, 3'd3, 32'h22, 1);
        applyStimulus(2'b01, 1, 3'd3, 32'h11, 1, 1, 3'd3, 32'h22, 1);
        applyStimulus(2'b10, 0, 3'd0, 32'd0, 0, 1, 3'd3, 32'h22, 1);
        applyStimulus(2'b00, 0, 3'd0, 32'd0, 0, 0, 3'd0, 32'd0, 0);
        applyStimulus(2'b00, 0, 3'd0, 32'd0, 0, 0, 3'd0, 32'd0, 0);
        checkOutput("hold_we",    64'(we),    64'd0);
        checkOutput("hold_wAddr", 64'(wAddr), 64'd3);
        checkOutput("hold_wData", 64'(wData), 64'h22);

        repeat (3) @(negedge clk);
        checkOutput("pending_writes", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
